// File: rtl/axi4_rr_mux_2to1.sv
// Two-requester AXI4 mux: independent round-robin AW/W and AR arbitration onto one master port.
// Bundle layout, MSB first: AW fields, awvalid, wdata, wstrb, wlast, wvalid, bready, AR fields, arvalid, rready.
module axi4_rr_mux_2to1 #(
  parameter int unsigned axi4_id_width_p   = 4,
  parameter int unsigned axi4_addr_width_p = 32,
  parameter int unsigned axi4_data_width_p = 32
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [2*axi4_id_width_p+2*axi4_addr_width_p+axi4_data_width_p+axi4_data_width_p/8+64-1:0] s0_axi4_i,
  output logic [2*axi4_id_width_p+axi4_data_width_p+10-1:0]                                          s0_axi4_o,
  input  logic [2*axi4_id_width_p+2*axi4_addr_width_p+axi4_data_width_p+axi4_data_width_p/8+64-1:0] s1_axi4_i,
  output logic [2*axi4_id_width_p+axi4_data_width_p+10-1:0]                                          s1_axi4_o,
  output logic [2*axi4_id_width_p+2*axi4_addr_width_p+axi4_data_width_p+axi4_data_width_p/8+66-1:0] m_axi4_o,
  input  logic [2*axi4_id_width_p+axi4_data_width_p+12-1:0]                                          m_axi4_i
);

  localparam int unsigned id_lp   = axi4_id_width_p;
  localparam int unsigned addr_lp = axi4_addr_width_p;
  localparam int unsigned data_lp = axi4_data_width_p;
  localparam int unsigned strb_lp = axi4_data_width_p / 8;

  typedef struct packed {
    logic [id_lp-1:0]   id;
    logic [addr_lp-1:0] addr;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic               lock;
    logic [3:0]         cache;
    logic [2:0]         prot;
    logic [3:0]         qos;
    logic [3:0]         region;
  } s_ax_t;

  typedef struct packed {
    logic [id_lp:0]     id;
    logic [addr_lp-1:0] addr;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic               lock;
    logic [3:0]         cache;
    logic [2:0]         prot;
    logic [3:0]         qos;
    logic [3:0]         region;
  } m_ax_t;

  typedef struct packed {
    s_ax_t              aw;
    logic               awvalid;
    logic [data_lp-1:0] wdata;
    logic [strb_lp-1:0] wstrb;
    logic               wlast;
    logic               wvalid;
    logic               bready;
    s_ax_t              ar;
    logic               arvalid;
    logic               rready;
  } s_mosi_t;

  typedef struct packed {
    m_ax_t              aw;
    logic               awvalid;
    logic [data_lp-1:0] wdata;
    logic [strb_lp-1:0] wstrb;
    logic               wlast;
    logic               wvalid;
    logic               bready;
    m_ax_t              ar;
    logic               arvalid;
    logic               rready;
  } m_mosi_t;

  typedef struct packed {
    logic               awready;
    logic               wready;
    logic [id_lp-1:0]   bid;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               arready;
    logic [id_lp-1:0]   rid;
    logic [data_lp-1:0] rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
  } s_miso_t;

  typedef struct packed {
    logic               awready;
    logic               wready;
    logic [id_lp:0]     bid;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               arready;
    logic [id_lp:0]     rid;
    logic [data_lp-1:0] rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
  } m_miso_t;

  typedef enum logic {W_IDLE, W_BUSY} w_state_e;
  typedef enum logic {R_IDLE, R_BUSY} r_state_e;

  s_mosi_t s0, s1, w_src;
  s_miso_t s0_o, s1_o;
  m_mosi_t m_o;
  m_miso_t m_i;

  assign s0        = s0_axi4_i;
  assign s1        = s1_axi4_i;
  assign m_i       = m_axi4_i;
  assign s0_axi4_o = s0_o;
  assign s1_axi4_o = s1_o;
  assign m_axi4_o  = m_o;

  // Requester tag lands in the extra ID MSB; lock is never forwarded.
  function automatic m_ax_t widen(input logic tag, input s_ax_t ax);
    m_ax_t r;
    r      = {tag, ax};
    r.lock = 1'b0;
    return r;
  endfunction

  w_state_e w_state_q;
  r_state_e r_state_q;
  m_ax_t    aw_q, ar_q;
  logic     wptr_q, wsel_q, aw_pend_q, w_pend_q, rptr_q;

  logic aw_sel, aw_grant, ar_sel, ar_grant, w_act, w_done, aw_hs;

  // Pointer breaks ties only; a lone valid requester always wins.
  assign aw_sel   = (s0.awvalid & s1.awvalid) ? wptr_q : s1.awvalid;
  assign aw_grant = ~reset_i & (w_state_q == W_IDLE) & (s0.awvalid | s1.awvalid);
  assign ar_sel   = (s0.arvalid & s1.arvalid) ? rptr_q : s1.arvalid;
  assign ar_grant = ~reset_i & (r_state_q == R_IDLE) & (s0.arvalid | s1.arvalid);

  assign w_src  = wsel_q ? s1 : s0;
  assign w_act  = (w_state_q == W_BUSY) & w_pend_q;
  assign w_done = w_act & w_src.wvalid & m_i.wready & w_src.wlast;
  assign aw_hs  = (w_state_q == W_BUSY) & aw_pend_q & m_i.awready;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_state_q <= W_IDLE;
      wptr_q    <= 1'b0;
      wsel_q    <= 1'b0;
      aw_q      <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: if (aw_grant) begin
          aw_q      <= widen(aw_sel, aw_sel ? s1.aw : s0.aw);
          wsel_q    <= aw_sel;
          wptr_q    <= ~aw_sel;
          aw_pend_q <= 1'b1;
          w_pend_q  <= 1'b1;
          w_state_q <= W_BUSY;
        end
        W_BUSY: begin
          if (aw_hs)  aw_pend_q <= 1'b0;
          if (w_done) w_pend_q  <= 1'b0;
          if (!aw_pend_q && !w_pend_q) w_state_q <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state_q <= R_IDLE;
      rptr_q    <= 1'b0;
      ar_q      <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (ar_grant) begin
          ar_q      <= widen(ar_sel, ar_sel ? s1.ar : s0.ar);
          rptr_q    <= ~ar_sel;
          r_state_q <= R_BUSY;
        end
        R_BUSY: if (m_i.arready) r_state_q <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    m_o  = '0;
    s0_o = '0;
    s1_o = '0;

    m_o.aw      = aw_q;
    m_o.awvalid = (w_state_q == W_BUSY) & aw_pend_q;
    m_o.wdata   = w_src.wdata;
    m_o.wstrb   = w_src.wstrb;
    m_o.wlast   = w_src.wlast;
    m_o.wvalid  = w_act & w_src.wvalid;
    m_o.ar      = ar_q;
    m_o.arvalid = (r_state_q == R_BUSY);

    s0_o.awready = aw_grant & ~aw_sel;
    s1_o.awready = aw_grant & aw_sel;
    s0_o.wready  = w_act & ~wsel_q & m_i.wready;
    s1_o.wready  = w_act & wsel_q & m_i.wready;
    s0_o.arready = ar_grant & ~ar_sel;
    s1_o.arready = ar_grant & ar_sel;

    // Responses are steered purely on the ID tag bit; nothing is buffered.
    s0_o.bid    = m_i.bid[id_lp-1:0];
    s1_o.bid    = m_i.bid[id_lp-1:0];
    s0_o.bresp  = m_i.bresp;
    s1_o.bresp  = m_i.bresp;
    s0_o.bvalid = m_i.bvalid & ~m_i.bid[id_lp];
    s1_o.bvalid = m_i.bvalid & m_i.bid[id_lp];
    m_o.bready  = m_i.bid[id_lp] ? s1.bready : s0.bready;

    s0_o.rid    = m_i.rid[id_lp-1:0];
    s1_o.rid    = m_i.rid[id_lp-1:0];
    s0_o.rdata  = m_i.rdata;
    s1_o.rdata  = m_i.rdata;
    s0_o.rresp  = m_i.rresp;
    s1_o.rresp  = m_i.rresp;
    s0_o.rlast  = m_i.rlast;
    s1_o.rlast  = m_i.rlast;
    s0_o.rvalid = m_i.rvalid & ~m_i.rid[id_lp];
    s1_o.rvalid = m_i.rvalid & m_i.rid[id_lp];
    m_o.rready  = m_i.rid[id_lp] ? s1.rready : s0.rready;
  end

endmodule

// File: tb/tb_axi4_rr_mux_2to1.sv
// Directed bench for axi4_rr_mux_2to1: arbitration order, W forwarding, B/R steering, reset mid-burst.
module tb_axi4_rr_mux_2to1;

  localparam int unsigned ID = 4;
  localparam int unsigned AD = 32;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [ID-1:0] id; logic [AD-1:0] addr; logic [7:0] len; logic [2:0] size;
    logic [1:0] burst; logic lock; logic [3:0] cache; logic [2:0] prot;
    logic [3:0] qos; logic [3:0] region;
  } s_ax_t;
  typedef struct packed {
    logic [ID:0] id; logic [AD-1:0] addr; logic [7:0] len; logic [2:0] size;
    logic [1:0] burst; logic lock; logic [3:0] cache; logic [2:0] prot;
    logic [3:0] qos; logic [3:0] region;
  } m_ax_t;
  typedef struct packed {
    s_ax_t aw; logic awvalid; logic [DW-1:0] wdata; logic [DW/8-1:0] wstrb;
    logic wlast; logic wvalid; logic bready; s_ax_t ar; logic arvalid; logic rready;
  } s_mosi_t;
  typedef struct packed {
    m_ax_t aw; logic awvalid; logic [DW-1:0] wdata; logic [DW/8-1:0] wstrb;
    logic wlast; logic wvalid; logic bready; m_ax_t ar; logic arvalid; logic rready;
  } m_mosi_t;
  typedef struct packed {
    logic awready; logic wready; logic [ID-1:0] bid; logic [1:0] bresp; logic bvalid;
    logic arready; logic [ID-1:0] rid; logic [DW-1:0] rdata; logic [1:0] rresp;
    logic rlast; logic rvalid;
  } s_miso_t;
  typedef struct packed {
    logic awready; logic wready; logic [ID:0] bid; logic [1:0] bresp; logic bvalid;
    logic arready; logic [ID:0] rid; logic [DW-1:0] rdata; logic [1:0] rresp;
    logic rlast; logic rvalid;
  } m_miso_t;

  logic clk = 1'b0;
  logic reset_i;
  s_mosi_t s0m, s1m;
  s_miso_t s0s, s1s;
  m_mosi_t mm;
  m_miso_t ms;
  logic [$bits(s_mosi_t)-1:0] s0_i, s1_i;
  logic [$bits(s_miso_t)-1:0] s0_o, s1_o;
  logic [$bits(m_mosi_t)-1:0] m_o;
  logic [$bits(m_miso_t)-1:0] m_i;

  assign s0_i = s0m;
  assign s1_i = s1m;
  assign m_i  = ms;
  assign s0s  = s0_o;
  assign s1s  = s1_o;
  assign mm   = m_o;

  axi4_rr_mux_2to1 #(
    .axi4_id_width_p(ID), .axi4_addr_width_p(AD), .axi4_data_width_p(DW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .s0_axi4_i(s0_i), .s0_axi4_o(s0_o),
    .s1_axi4_i(s1_i), .s1_axi4_o(s1_o),
    .m_axi4_o(m_o),   .m_axi4_i(m_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One single-beat write from an already-asserted awvalid; sel is the expected winner.
  task automatic wr1(input logic sel, input logic [4:0] exp_id);
    settle();
    chk("awready_win",  64'(sel ? s1s.awready : s0s.awready), 64'(1));
    chk("awready_lose", 64'(sel ? s0s.awready : s1s.awready), 64'(0));
    tick();
    if (sel) s1m.awvalid = 1'b0; else s0m.awvalid = 1'b0;
    settle();
    chk("m_awvalid", 64'(mm.awvalid), 64'(1));
    chk("m_awid",    64'(mm.aw.id),   64'(exp_id));
    ms.awready = 1'b1;
    ms.wready  = 1'b1;
    if (sel) begin s1m.wvalid = 1'b1; s1m.wlast = 1'b1; s1m.wdata = 32'h11; end
    else     begin s0m.wvalid = 1'b1; s0m.wlast = 1'b1; s0m.wdata = 32'h10; end
    settle();
    chk("w_fwd",       64'(mm.wdata), 64'(sel ? 32'h11 : 32'h10));
    chk("wready_lose", 64'(sel ? s0s.wready : s1s.wready), 64'(0));
    tick();
    s0m.wvalid = 1'b0; s0m.wlast = 1'b0;
    s1m.wvalid = 1'b0; s1m.wlast = 1'b0;
    ms.awready = 1'b0;
    ms.wready  = 1'b0;
    settle();
    chk("m_awvalid_done", 64'(mm.awvalid), 64'(0));
    tick();
  endtask

  initial begin
    s0m = '0; s1m = '0; ms = '0;
    reset_i = 1'b1;
    tick();
    tick();
    s0m.awvalid = 1'b1;
    s1m.arvalid = 1'b1;
    settle();
    chk("rst_awready", 64'(s0s.awready), 64'(0));
    chk("rst_arready", 64'(s1s.arready), 64'(0));
    chk("rst_m_awvalid", 64'(mm.awvalid), 64'(0));
    chk("rst_m_wvalid",  64'(mm.wvalid),  64'(0));
    chk("rst_m_arvalid", 64'(mm.arvalid), 64'(0));
    s0m.awvalid = 1'b0;
    s1m.arvalid = 1'b0;
    reset_i = 1'b0;
    tick();

    // Simultaneous pair after reset: s0 first, then s1.
    s0m.aw.id = 4'd1; s0m.aw.addr = 32'h100; s0m.awvalid = 1'b1;
    s1m.aw.id = 4'd3; s1m.aw.addr = 32'h200; s1m.awvalid = 1'b1;
    wr1(1'b0, 5'h01);
    wr1(1'b1, 5'h13);

    // Lone s0 burst of 4 beats, then B back to s0.
    s0m.aw = '0;
    s0m.aw.addr = 32'h1000; s0m.aw.len = 8'd3; s0m.aw.id = 4'd2;
    s0m.aw.qos = 4'd5; s0m.aw.region = 4'd3; s0m.aw.lock = 1'b1;
    s0m.awvalid = 1'b1;
    settle();
    chk("a_awready", 64'(s0s.awready), 64'(1));
    tick();
    s0m.awvalid = 1'b0;
    settle();
    chk("a_m_awvalid", 64'(mm.awvalid),   64'(1));
    chk("a_m_awid",    64'(mm.aw.id),     64'(5'h02));
    chk("a_m_awaddr",  64'(mm.aw.addr),   64'(32'h1000));
    chk("a_m_awlen",   64'(mm.aw.len),    64'(3));
    chk("a_m_awlock",  64'(mm.aw.lock),   64'(0));
    chk("a_m_awqos",   64'(mm.aw.qos),    64'(5));
    chk("a_m_awreg",   64'(mm.aw.region), 64'(3));
    ms.awready = 1'b1;
    ms.wready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0m.wvalid = 1'b1;
      s0m.wdata  = 32'hA0 + 32'(i);
      s0m.wlast  = (i == 3);
      settle();
      chk("a_m_wvalid", 64'(mm.wvalid), 64'(1));
      chk("a_m_wdata",  64'(mm.wdata),  64'(32'hA0 + 32'(i)));
      chk("a_m_wlast",  64'(mm.wlast),  64'(i == 3));
      chk("a_s0_wready", 64'(s0s.wready), 64'(1));
      if (i > 0) chk("a_awvalid_after_hs", 64'(mm.awvalid), 64'(0));
      tick();
    end
    s0m.wvalid = 1'b0; s0m.wlast = 1'b0;
    ms.awready = 1'b0; ms.wready = 1'b0;
    tick();
    ms.bvalid = 1'b1; ms.bid = 5'h02; ms.bresp = 2'b10;
    s0m.bready = 1'b1;
    settle();
    chk("a_s0_bvalid", 64'(s0s.bvalid), 64'(1));
    chk("a_s0_bid",    64'(s0s.bid),    64'(2));
    chk("a_s0_bresp",  64'(s0s.bresp),  64'(2));
    chk("a_s1_bvalid", 64'(s1s.bvalid), 64'(0));
    chk("a_m_bready",  64'(mm.bready),  64'(1));
    tick();
    ms.bvalid = 1'b0; s0m.bready = 1'b0;

    // Last write winner was s0, so the repeat pair goes s1 then s0.
    s0m.aw = '0; s0m.aw.id = 4'd1; s0m.awvalid = 1'b1;
    s1m.awvalid = 1'b1;
    wr1(1'b1, 5'h13);
    wr1(1'b0, 5'h01);

    // s1 read with arready held low three cycles.
    s1m.ar = '0; s1m.ar.id = 4'd5; s1m.ar.addr = 32'h2000; s1m.arvalid = 1'b1;
    settle();
    chk("c_s1_arready", 64'(s1s.arready), 64'(1));
    chk("c_s0_arready", 64'(s0s.arready), 64'(0));
    tick();
    s1m.arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ms.arready = 1'b1;
      settle();
      chk("c_m_arvalid", 64'(mm.arvalid), 64'(1));
      chk("c_m_arid",    64'(mm.ar.id),   64'(5'h15));
      chk("c_m_araddr",  64'(mm.ar.addr), 64'(32'h2000));
      tick();
    end
    ms.arready = 1'b0;
    settle();
    chk("c_m_arvalid_done", 64'(mm.arvalid), 64'(0));
    ms.rvalid = 1'b1; ms.rid = 5'h15; ms.rdata = 32'hDEAD; ms.rlast = 1'b1; ms.rresp = 2'b01;
    s1m.rready = 1'b1;
    settle();
    chk("c_s1_rvalid", 64'(s1s.rvalid), 64'(1));
    chk("c_s1_rid",    64'(s1s.rid),    64'(5));
    chk("c_s1_rdata",  64'(s1s.rdata),  64'(32'hDEAD));
    chk("c_s1_rlast",  64'(s1s.rlast),  64'(1));
    chk("c_s1_rresp",  64'(s1s.rresp),  64'(1));
    chk("c_s0_rvalid", 64'(s0s.rvalid), 64'(0));
    chk("c_m_rready",  64'(mm.rready),  64'(1));
    tick();
    ms = '0; s1m.rready = 1'b0;

    // s0 8-beat write concurrent with an s1 read and its response.
    s0m.aw = '0; s0m.aw.id = 4'd1; s0m.aw.len = 8'd7; s0m.aw.addr = 32'h4000; s0m.awvalid = 1'b1;
    s1m.ar = '0; s1m.ar.id = 4'd6; s1m.ar.addr = 32'h3000; s1m.arvalid = 1'b1;
    settle();
    chk("d_s0_awready", 64'(s0s.awready), 64'(1));
    chk("d_s1_arready", 64'(s1s.arready), 64'(1));
    tick();
    s0m.awvalid = 1'b0; s1m.arvalid = 1'b0;
    ms.awready = 1'b1; ms.wready = 1'b1; ms.arready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s0m.wvalid = 1'b1;
      s0m.wdata  = 32'hB0 + 32'(i);
      s0m.wlast  = (i == 7);
      ms.rvalid  = (i == 2);
      ms.rid     = 5'h16; ms.rdata = 32'hBEEF; ms.rlast = 1'b1;
      s1m.rready = 1'b1;
      settle();
      chk("d_m_wdata",   64'(mm.wdata),   64'(32'hB0 + 32'(i)));
      chk("d_s0_wready", 64'(s0s.wready), 64'(1));
      if (i == 0) chk("d_m_arid", 64'(mm.ar.id), 64'(5'h16));
      if (i < 2)  chk("d_m_arvalid", 64'(mm.arvalid), 64'(i == 0));
      if (i == 2) begin
        chk("d_s1_rvalid", 64'(s1s.rvalid), 64'(1));
        chk("d_s1_rdata",  64'(s1s.rdata),  64'(32'hBEEF));
        chk("d_s0_rvalid", 64'(s0s.rvalid), 64'(0));
      end
      tick();
    end
    s0m.wvalid = 1'b0; s0m.wlast = 1'b0; s1m.rready = 1'b0;
    ms = '0;
    tick();

    // W beats complete while AW waits five cycles for awready.
    s0m.aw = '0; s0m.aw.id = 4'd4; s0m.aw.len = 8'd1; s0m.aw.addr = 32'h5000; s0m.awvalid = 1'b1;
    settle();
    chk("e_s0_awready", 64'(s0s.awready), 64'(1));
    tick();
    s0m.awvalid = 1'b0;
    ms.wready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      s0m.wvalid  = (c < 2);
      s0m.wdata   = 32'hC0 + 32'(c);
      s0m.wlast   = (c == 1);
      s0m.awvalid = (c >= 2);
      ms.awready  = (c == 5);
      settle();
      chk("e_m_awvalid",  64'(mm.awvalid),  64'(1));
      chk("e_m_wvalid",   64'(mm.wvalid),   64'(c < 2));
      chk("e_s0_wready",  64'(s0s.wready),  64'(c < 2));
      chk("e_busy_awrdy", 64'(s0s.awready), 64'(0));
      tick();
    end
    ms.awready = 1'b0;
    settle();
    chk("e_m_awvalid_done", 64'(mm.awvalid),  64'(0));
    chk("e_still_busy",     64'(s0s.awready), 64'(0));
    tick();
    s1m.wvalid = 1'b1;
    settle();
    chk("e_idle_awready", 64'(s0s.awready), 64'(1));
    chk("e_noaw_wready",  64'(s1s.wready),  64'(0));
    chk("e_noaw_mwvalid", 64'(mm.wvalid),   64'(0));
    tick();

    // Reset in the middle of a W burst.
    s1m.wvalid = 1'b0; s0m.awvalid = 1'b0;
    s0m.wvalid = 1'b1; s0m.wdata = 32'hD0; s0m.wlast = 1'b0;
    settle();
    chk("f_m_wvalid_pre", 64'(mm.wvalid), 64'(1));
    reset_i = 1'b1;
    tick();
    chk("f_m_awvalid", 64'(mm.awvalid), 64'(0));
    chk("f_m_wvalid",  64'(mm.wvalid),  64'(0));
    chk("f_m_arvalid", 64'(mm.arvalid), 64'(0));
    reset_i = 1'b0;
    s0m = '0; s1m = '0;
    s0m.awvalid = 1'b1; s1m.awvalid = 1'b1;
    settle();
    chk("f_ptr_s0", 64'(s0s.awready), 64'(1));
    chk("f_ptr_s1", 64'(s1s.awready), 64'(0));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
